// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   - FSM state encodings (raw localparams plus the enum built on them)
//   - default clocks-per-bit for a 100 MHz board clock at 115200 baud
//   - serial line idle level
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_t;

  // 100_000_000 / 115_200 rounded to the nearest integer
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter for the UART paths.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   i_en     in   count while high; counter is held at 0 while low
//   o_tick   out  high during the last cycle of a bit period (count == CLKS_PER_BIT-1)
//   o_count  out  current count, 0 .. CLKS_PER_BIT-1
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic          o_tick,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (!i_en) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick  = i_en && (r_count == LAST);
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter (DATA_BITS payload bits, LSB first).
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   tx_data    in   byte to send, sampled only on the handshake edge
//   tx_valid   in   upstream has a byte on tx_data
//   tx_ready   out  block accepts a byte this cycle (state == IDLE)
//   tx         out  registered serial line, idle high
//   tx_busy    out  frame in progress (complement of tx_ready)
//   tx_done    out  one-cycle pulse when the frame completes
//   dbg_state  out  current FSM state (uart_pkg encoding)
//
// Handshake: a byte is transferred on a rising clk edge where
// tx_valid && tx_ready; upstream holds tx_valid and tx_data until then,
// and nothing on tx_data/tx_valid is looked at while tx_ready is low.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] STOP_END = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic [CW-1:0]        w_count;
  logic                 w_stop_end;
  logic                 w_baud_en;

  // The FSM leaves STOP one cycle early: the IDLE cycle that follows still
  // drives the line high, so the stop bit is a full CLKS_PER_BIT long and a
  // held tx_valid starts the next frame with no extra idle time.
  assign w_stop_end = (r_state == STOP) && (w_count == STOP_END);

  // Disabling on the last stop cycle leaves the counter at 0 for IDLE.
  assign w_baud_en = (r_state != IDLE) && !w_stop_end;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_baud_en),
    .o_tick  (w_tick),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_tx      <= LINE_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_valid && r_ready) begin
            r_shreg <= tx_data;
            r_state <= START;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_tx      <= r_shreg[0];
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          // r_shreg[0] is always the bit currently on the line
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_state <= STOP;
              r_tx    <= LINE_IDLE;
            end else begin
              r_shreg   <= r_shreg >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shreg[1];
            end
          end
        end
        STOP: begin
          if (w_stop_end) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign tx_ready  = r_ready;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CA = 4;  // main DUT clocks per bit
  localparam int CB = 2;  // boundary DUT clocks per bit

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  uart_tx #(.CLKS_PER_BIT(CA), .DATA_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a),
    .dbg_state(st_a)
  );

  uart_tx #(.CLKS_PER_BIT(CB), .DATA_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e_now = 0;

  logic [7:0] exp_q[$];

  int         m_start[2]  = '{-1000000, -1000000};  // edge index of last handshake
  logic [7:0] m_byte[2]   = '{8'h00, 8'h00};
  int         hs_cnt[2]   = '{0, 0};
  int         done_exp[2] = '{0, 0};
  int         done_obs[2] = '{0, 0};
  bit         rx_act[2]   = '{1'b0, 1'b0};
  int         rx_cnt[2]   = '{0, 0};
  logic [7:0] rx_byte[2]  = '{8'h00, 8'h00};
  int         rx_frames   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line level at a given offset (in clocks) from the handshake edge:
  // start bit, 8 data bits LSB first, stop bit, each c clocks long.
  function automatic logic exp_line(input int off, input int c, input logic [7:0] b);
    int bitn;
    if (off < 0 || off >= 10 * c) return 1'b1;
    bitn = off / c;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_state(input int off, input int c);
    if (off < 0 || off >= 10 * c - 1) return 2'd0;
    if (off < c)     return 2'd1;
    if (off < 9 * c) return 2'd2;
    return 2'd3;
  endfunction

  // Called at every rising edge with the inputs the DUT sees on that edge.
  // The block is ready on edge e unless a frame started within the last 10c edges.
  task automatic model_edge(input int d, input int c, input logic v, input logic [7:0] din, input int e);
    if (!rst) begin
      m_start[d] = -1000000;
      rx_act[d]  = 1'b0;
      exp_q.delete();
    end else if (v && (e >= m_start[d] + 10 * c)) begin
      m_start[d] = e;
      m_byte[d]  = din;
      exp_q.push_back(din);
      hs_cnt[d]++;
    end
  endtask

  // Called 1 time unit after edge e: compare outputs, then run a UART receiver
  // on the observed line that samples mid-bit and checks against exp_q.
  task automatic model_check(input int d, input int c, input logic t, input logic rdy,
                             input logic bz, input logic dn, input logic [1:0] st, input int e);
    int   off;
    logic in_frame;
    off      = e - m_start[d];
    in_frame = (off >= 0) && (off < 10 * c - 1);
    check($sformatf("tx%0d@%0d", d, e),    t,   exp_line(off, c, m_byte[d]));
    check($sformatf("ready%0d@%0d", d, e), rdy, !in_frame);
    check($sformatf("busy%0d@%0d", d, e),  bz,  in_frame);
    check($sformatf("done%0d@%0d", d, e),  dn,  (off == 10 * c - 1));
    check($sformatf("state%0d@%0d", d, e), st,  exp_state(off, c));
    if (dn) done_obs[d]++;
    if (off == 10 * c - 1) done_exp[d]++;

    if (!rst) begin
      rx_act[d] = 1'b0;
    end else begin
      if (!rx_act[d] && (t == 1'b0)) begin
        rx_act[d]  = 1'b1;
        rx_cnt[d]  = 0;
        rx_byte[d] = 8'h00;
      end
      if (rx_act[d]) begin
        if (rx_cnt[d] == c / 2) check($sformatf("rx_start%0d", d), t, 1'b0);
        for (int j = 0; j < 8; j++)
          if (rx_cnt[d] == (j + 1) * c + c / 2) rx_byte[d][j] = t;
        if (rx_cnt[d] == 9 * c + c / 2) begin
          check($sformatf("rx_stop%0d", d), t, 1'b1);
          check($sformatf("rx_pending%0d", d), (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) check($sformatf("rx_byte%0d", d), rx_byte[d], exp_q.pop_front());
          rx_act[d] = 1'b0;
          rx_frames++;
        end
        rx_cnt[d]++;
      end
    end
  endtask

  always @(posedge clk) begin
    e_now = cyc;
    cyc++;
    model_edge(0, CA, valid_a, data_a, e_now);
    model_edge(1, CB, valid_b, data_b, e_now);
    #1;
    model_check(0, CA, tx_a, ready_a, busy_a, done_a, st_a, e_now);
    model_check(1, CB, tx_b, ready_b, busy_b, done_b, st_b, e_now);
  end

  // ---------------- driver tasks ----------------
  // Present a byte at a falling edge and hold tx_valid until the handshake.
  // tx_valid is left high on return (at the falling edge after the handshake).
  task automatic send(input int d, input logic [7:0] b);
    int h0;
    int n;
    @(negedge clk);
    if (d == 0) begin data_a = b; valid_a = 1'b1; end
    else        begin data_b = b; valid_b = 1'b1; end
    h0 = hs_cnt[d];
    n  = 0;
    while (hs_cnt[d] == h0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("hs_wait%0d_%02h", d, b), (hs_cnt[d] != h0), 1'b1);
  endtask

  task automatic drop(input int d);
    @(negedge clk);
    if (d == 0) valid_a = 1'b0;
    else        valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    int gap;

    // reset held for 5 cycles
    rst = 1'b0;
    idle(5);
    check("rst_tx",    tx_a,    1'b1);
    check("rst_ready", ready_a, 1'b1);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_done",  done_a,  1'b0);
    rst = 1'b1;
    idle(100);
    check("idle_tx_after_100", tx_a, 1'b1);

    // single frame A5
    send(0, 8'hA5);
    drop(0);
    idle(45);

    // back-to-back 55, 0F with tx_valid held
    send(0, 8'h55);
    send(0, 8'h0F);
    drop(0);
    idle(45);

    // data changes while the frame is in DATA
    send(0, 8'h3C);
    idle(CA + 4);
    send(0, 8'hFF);
    drop(0);
    idle(45);

    // asynchronous reset during data bit 3 of 00
    send(0, 8'h00);
    idle(4 * CA + 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx",    tx_a,    1'b1);
    check("async_rst_ready", ready_a, 1'b1);
    check("async_rst_busy",  busy_a,  1'b0);
    check("async_rst_done",  done_a,  1'b0);
    valid_a = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3);
    send(0, 8'h81);
    drop(0);
    idle(45);

    // boundary: two clocks per bit, all-ones byte
    send(1, 8'hFF);
    drop(1);
    idle(25);

    // randomized traffic with input churn while busy
    for (int i = 0; i < 20; i++) begin
      send(0, 8'($urandom_range(0, 255)));
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(0, 30);
      if (mode == 1) begin
        @(negedge clk);
        valid_a = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          data_a = 8'($urandom_range(0, 255));
        end
      end else if (mode == 2) begin
        repeat (gap) begin
          @(negedge clk);
          data_a = 8'($urandom_range(0, 255));
        end
      end
    end
    drop(0);
    idle(60);

    check("done_count_a", done_obs[0], done_exp[0]);
    check("done_count_b", done_obs[1], done_exp[1]);
    check("frames_decoded", rx_frames, done_exp[0] + done_exp[1]);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // bound on total run time
  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
